// File: rtl/fuel_controller_if.sv
// rtl/fuel_controller_if.sv - frame-event and status bundle between game logic and fuel controller
interface fuel_controller_if #(
  parameter int W = 7
);
  logic         startOfFrame;
  logic         gameStart;
  logic         moving;
  logic         fuelHit;
  logic         carHit;
  logic         truckHit;
  logic         specialHit;
  logic [W-1:0] fuelLevel;
  logic         fuelLow;
  logic         playerFreeze;
  logic         gameOver;
  logic         crashPulse;
  logic         refillPulse;
  logic [1:0]   state;

  modport master (
    output startOfFrame, gameStart, moving, fuelHit, carHit, truckHit, specialHit,
    input  fuelLevel, fuelLow, playerFreeze, gameOver, crashPulse, refillPulse, state
  );

  modport slave (
    input  startOfFrame, gameStart, moving, fuelHit, carHit, truckHit, specialHit,
    output fuelLevel, fuelLow, playerFreeze, gameOver, crashPulse, refillPulse, state
  );
endinterface

// File: rtl/fuel_controller.sv
// rtl/fuel_controller.sv - per-frame fuel level and run/crash/game-over sequencer
module fuel_controller #(
  parameter int W             = 7,
  parameter int FUEL_MAX      = 100,
  parameter int FUEL_INIT     = 100,
  parameter int BURN_FRAMES   = 30,
  parameter int REFILL_AMT    = 20,
  parameter int CRASH_PENALTY = 10,
  parameter int CRASH_FRAMES  = 60
) (
  input  logic             clk,
  input  logic             reset,
  fuel_controller_if.slave bus
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] CRASH     = 2'd2;
  localparam logic [1:0] GAME_OVER = 2'd3;

  localparam int FW = W + 1;
  localparam int BW = $clog2(BURN_FRAMES + 1);
  localparam int CW = $clog2(CRASH_FRAMES + 1);

  localparam logic [FW-1:0] MAX_X    = FW'(FUEL_MAX);
  localparam logic [FW-1:0] REFILL_X = FW'(REFILL_AMT);
  localparam logic [FW-1:0] PEN_CAR  = FW'(CRASH_PENALTY);
  localparam logic [FW-1:0] PEN_TRK  = FW'(2 * CRASH_PENALTY);
  localparam logic [BW-1:0] BURN_LAST  = BW'(BURN_FRAMES - 1);
  localparam logic [CW-1:0] CRASH_LAST = CW'(CRASH_FRAMES - 1);

  logic [1:0]    st;
  logic [W-1:0]  fuel;
  logic [BW-1:0] burn_cnt;
  logic [CW-1:0] crash_cnt;
  logic          pend_fuel, pend_car, pend_truck, pend_special;
  logic          crash_pulse, refill_pulse;

  logic          crash_hit;
  logic          burn_wrap;
  logic [FW-1:0] fuel_ext, diff, sum, fuel_pick, fuel_run;

  // Frame result for RUN: crash penalty or pickup, then burn, all saturated to [0, FUEL_MAX]
  always_comb begin
    fuel_ext  = {1'b0, fuel};
    crash_hit = pend_truck | pend_car;
    burn_wrap = bus.moving && (burn_cnt == BURN_LAST);
    diff      = fuel_ext - (pend_truck ? PEN_TRK : PEN_CAR);
    sum       = fuel_ext + REFILL_X;
    fuel_pick = fuel_ext;
    if (crash_hit) begin
      // Borrow out of the extra top bit means the penalty exceeded the fuel left
      fuel_pick = diff[W] ? '0 : diff;
    end else if (pend_special) begin
      fuel_pick = MAX_X;
    end else if (pend_fuel) begin
      fuel_pick = (sum > MAX_X) ? MAX_X : sum;
    end
    fuel_run = fuel_pick;
    if (!crash_hit && burn_wrap && (fuel_pick != '0)) begin
      fuel_run = fuel_pick - 1'b1;
    end
  end

  // Event latching, game-state sequencing and one-cycle result pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= IDLE;
      fuel         <= '0;
      burn_cnt     <= '0;
      crash_cnt    <= '0;
      pend_fuel    <= 1'b0;
      pend_car     <= 1'b0;
      pend_truck   <= 1'b0;
      pend_special <= 1'b0;
      crash_pulse  <= 1'b0;
      refill_pulse <= 1'b0;
    end else begin
      crash_pulse  <= 1'b0;
      refill_pulse <= 1'b0;
      // Hits arriving with startOfFrame open the new frame's window
      pend_fuel    <= bus.fuelHit    | (pend_fuel    & ~bus.startOfFrame);
      pend_car     <= bus.carHit     | (pend_car     & ~bus.startOfFrame);
      pend_truck   <= bus.truckHit   | (pend_truck   & ~bus.startOfFrame);
      pend_special <= bus.specialHit | (pend_special & ~bus.startOfFrame);
      case (st)
        IDLE, GAME_OVER: begin
          if (bus.gameStart) begin
            st       <= RUN;
            fuel     <= W'(FUEL_INIT);
            burn_cnt <= '0;
          end
        end
        RUN: begin
          if (bus.startOfFrame) begin
            fuel <= fuel_run[W-1:0];
            if (crash_hit) begin
              crash_cnt   <= CRASH_LAST;
              crash_pulse <= 1'b1;
            end else begin
              refill_pulse <= pend_special | pend_fuel;
              if (bus.moving) begin
                burn_cnt <= burn_wrap ? '0 : burn_cnt + 1'b1;
              end
            end
            if (fuel_run == '0) begin
              st <= GAME_OVER;
            end else if (crash_hit) begin
              st <= CRASH;
            end
          end
        end
        CRASH: begin
          if (bus.startOfFrame) begin
            if (crash_cnt == '0) begin
              st       <= RUN;
              burn_cnt <= '0;
            end else begin
              crash_cnt <= crash_cnt - 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.fuelLevel    = fuel;
  assign bus.fuelLow      = (fuel <= W'(FUEL_MAX / 4)) && (st != IDLE);
  assign bus.playerFreeze = (st != RUN);
  assign bus.gameOver     = (st == GAME_OVER);
  assign bus.crashPulse   = crash_pulse;
  assign bus.refillPulse  = refill_pulse;
  assign bus.state        = st;
endmodule
